// File: rtl/store_align.sv
// Store formatter: turns SB/SH/SW requests into word-aligned, lane-replicated memory writes through a 2-entry FIFO.
// Optional macro STORE_ALIGN_MISALIGN_TRAP_EN rejects misaligned SH/SW like reserved-size stores.
module store_align #(
    parameter int BIG_ENDIAN = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_size,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        store_err,
    output logic [31:0] err_addr
);

    localparam logic BE_LANES = (BIG_ENDIAN != 0);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

    entry_t [1:0] fifo_q, fifo_d;
    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         store_err_q, store_err_d;
    logic [31:0]  err_addr_q, err_addr_d;

    entry_t fmt;
    entry_t head;
    logic   fmt_reject;
    logic   accept;
    logic   push;
    logic   pop;

    // Formatting happens on the incoming request so the FIFO holds ready-to-write entries.
    always_comb begin
        fmt        = '0;
        fmt_reject = 1'b0;
        fmt.addr   = {in_addr[31:2], 2'b00};
        case (in_size)
            2'b00: begin
                fmt.wdata = {4{in_data[7:0]}};
                fmt.be    = BE_LANES ? (4'b1000 >> in_addr[1:0]) : (4'b0001 << in_addr[1:0]);
            end
            2'b01: begin
                fmt.wdata = {2{in_data[15:0]}};
                fmt.be    = (in_addr[1] ^ BE_LANES) ? 4'b1100 : 4'b0011;
`ifdef STORE_ALIGN_MISALIGN_TRAP_EN
                fmt_reject = in_addr[0];
`else
                fmt_reject = 1'b0;
`endif
            end
            2'b10: begin
                fmt.wdata = in_data;
                fmt.be    = 4'b1111;
`ifdef STORE_ALIGN_MISALIGN_TRAP_EN
                fmt_reject = |in_addr[1:0];
`else
                fmt_reject = 1'b0;
`endif
            end
            default: begin
                fmt_reject = 1'b1;
            end
        endcase
    end

    assign in_ready  = (count_q < 2'd2);
    assign mem_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !fmt_reject;
    assign pop       = mem_valid && mem_ready;

    always_comb begin
        fifo_d      = fifo_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        store_err_d = accept && fmt_reject;
        err_addr_d  = err_addr_q;

        if (push) begin
            fifo_d[wr_ptr_q] = fmt;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (store_err_d) begin
            err_addr_d = in_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q      <= '0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            store_err_q <= 1'b0;
            err_addr_q  <= 32'd0;
        end else begin
            fifo_q      <= fifo_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            store_err_q <= store_err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Memory-side fields read as zero whenever nothing is presented.
    assign head      = fifo_q[rd_ptr_q];
    assign mem_addr  = mem_valid ? head.addr  : 32'd0;
    assign mem_wdata = mem_valid ? head.wdata : 32'd0;
    assign mem_be    = mem_valid ? head.be    : 4'd0;
    assign store_err = store_err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_store_align.sv
// Scoreboard bench for store_align: one little-endian and one big-endian instance share stimulus,
// a behavioural model predicts writes and error pulses, and a negedge monitor compares.
module tb_store_align;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_size = 2'd0;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_data = 32'd0;
    logic        mem_ready = 1'b0;

    logic        in_ready_le, mem_valid_le, store_err_le;
    logic [31:0] mem_addr_le, mem_wdata_le, err_addr_le;
    logic [3:0]  mem_be_le;
    logic        in_ready_be, mem_valid_be, store_err_be;
    logic [31:0] mem_addr_be, mem_wdata_be, err_addr_be;
    logic [3:0]  mem_be_be;

    store_align #(.BIG_ENDIAN(0)) dut_le (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_le),
        .in_size(in_size), .in_addr(in_addr), .in_data(in_data),
        .mem_valid(mem_valid_le), .mem_ready(mem_ready), .mem_addr(mem_addr_le),
        .mem_wdata(mem_wdata_le), .mem_be(mem_be_le),
        .store_err(store_err_le), .err_addr(err_addr_le)
    );

    store_align #(.BIG_ENDIAN(1)) dut_be (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_be),
        .in_size(in_size), .in_addr(in_addr), .in_data(in_data),
        .mem_valid(mem_valid_be), .mem_ready(mem_ready), .mem_addr(mem_addr_be),
        .mem_wdata(mem_wdata_be), .mem_be(mem_be_be),
        .store_err(store_err_be), .err_addr(err_addr_be)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  beLe;
        logic [3:0]  beBe;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } err_t;

    exp_t        expQ[$];
    err_t        errQ[$];
    logic [31:0] modelErrAddr = 32'd0;
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;
    int          readyPct = 100;
    int          lastStalls = 0;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%08h expected=%08h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: lane selection from the byte offset with plain arithmetic.
    function automatic exp_t buildExpected(input logic [1:0] size, input logic [31:0] addr,
                                           input logic [31:0] data, input int cyc);
        exp_t        e;
        int unsigned off;
        int unsigned half;
        off    = addr % 4;
        half   = (addr / 2) % 2;
        e.addr = addr - off;
        e.cyc  = cyc;
        case (size)
            2'd0: begin
                e.wdata = (data % 256) * 32'h0101_0101;
                e.beLe  = 4'(1 << off);
                e.beBe  = 4'(1 << (3 - off));
            end
            2'd1: begin
                e.wdata = (data % 65536) * 32'h0001_0001;
                e.beLe  = 4'(3 << (2 * half));
                e.beBe  = 4'(3 << (2 * (1 - half)));
            end
            default: begin
                e.wdata = data;
                e.beLe  = 4'hF;
                e.beBe  = 4'hF;
            end
        endcase
        return e;
    endfunction

    function automatic bit isReject(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
`ifdef STORE_ALIGN_MISALIGN_TRAP_EN
        if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
        mem_ready = ($urandom_range(0, 99) < readyPct);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) nextCycle();
    endtask

    // Holds the request until accepted; optionally opens mem_ready after a number of stalled cycles.
    task automatic applyStimulus(input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] data, input int releaseAfter);
        int stalls;
        bit done;
        stalls   = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        in_size  = size;
        in_addr  = addr;
        in_data  = data;
        while (!done) begin
            @(negedge clk);
            if (in_ready_le) begin
                if (isReject(size, addr)) begin
                    errQ.push_back('{addr: addr, cyc: cycle + 1});
                end else begin
                    expQ.push_back(buildExpected(size, addr, data, cycle + 1));
                end
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 64) begin
                    checkOutput("accept_timeout", 32'(stalls), 32'd64);
                    done = 1'b1;
                end
            end
            nextCycle();
            if (!done && releaseAfter > 0 && stalls == releaseAfter) begin
                readyPct  = 100;
                mem_ready = 1'b1;
            end
        end
        in_valid   = 1'b0;
        lastStalls = stalls;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_mem_valid_le"}, 32'(mem_valid_le), 32'd0);
        checkOutput({tag, "_mem_valid_be"}, 32'(mem_valid_be), 32'd0);
        checkOutput({tag, "_in_ready_le"},  32'(in_ready_le),  32'd1);
        checkOutput({tag, "_in_ready_be"},  32'(in_ready_be),  32'd1);
        checkOutput({tag, "_mem_addr"},     mem_addr_le | mem_addr_be, 32'd0);
        checkOutput({tag, "_mem_wdata"},    mem_wdata_le | mem_wdata_be, 32'd0);
        checkOutput({tag, "_mem_be"},       32'(mem_be_le | mem_be_be), 32'd0);
        checkOutput({tag, "_store_err"},    32'(store_err_le | store_err_be), 32'd0);
        checkOutput({tag, "_err_addr"},     err_addr_le | err_addr_be, 32'd0);
    endtask

    // Monitor: compares both instances against the model mid-cycle, popping on each handshake.
    always @(negedge clk) begin : monitor
        int   occ;
        logic expValid;
        logic expErr;
        if (rst_n) begin
            occ = 0;
            foreach (expQ[i]) if (expQ[i].cyc <= cycle) occ++;
            expValid = (occ > 0);
            checkOutput("in_ready_le",  32'(in_ready_le),  32'(occ < 2));
            checkOutput("in_ready_be",  32'(in_ready_be),  32'(occ < 2));
            checkOutput("mem_valid_le", 32'(mem_valid_le), 32'(expValid));
            checkOutput("mem_valid_be", 32'(mem_valid_be), 32'(expValid));
            if (expValid) begin
                checkOutput("mem_addr_le",  mem_addr_le,  expQ[0].addr);
                checkOutput("mem_addr_be",  mem_addr_be,  expQ[0].addr);
                checkOutput("mem_wdata_le", mem_wdata_le, expQ[0].wdata);
                checkOutput("mem_wdata_be", mem_wdata_be, expQ[0].wdata);
                checkOutput("mem_be_le",    32'(mem_be_le), 32'(expQ[0].beLe));
                checkOutput("mem_be_be",    32'(mem_be_be), 32'(expQ[0].beBe));
                if (mem_ready) void'(expQ.pop_front());
            end else begin
                checkOutput("idle_addr",  mem_addr_le | mem_addr_be, 32'd0);
                checkOutput("idle_wdata", mem_wdata_le | mem_wdata_be, 32'd0);
                checkOutput("idle_be",    32'(mem_be_le | mem_be_be), 32'd0);
            end
            expErr = 1'b0;
            if (errQ.size() > 0) begin
                if (errQ[0].cyc == cycle) begin
                    expErr       = 1'b1;
                    modelErrAddr = errQ[0].addr;
                    void'(errQ.pop_front());
                end
            end
            checkOutput("store_err_le", 32'(store_err_le), 32'(expErr));
            checkOutput("store_err_be", 32'(store_err_be), 32'(expErr));
            checkOutput("err_addr_le",  err_addr_le, modelErrAddr);
            checkOutput("err_addr_be",  err_addr_be, modelErrAddr);
        end
    end

    initial begin
        logic [1:0] sz;
        rst_n     = 1'b0;
        readyPct  = 100;
        mem_ready = 1'b1;
        #2;
        checkReset("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] directed SB / SH lane cases");
        applyStimulus(2'd0, 32'h0000_1003, 32'h1234_5678, 0);
        applyStimulus(2'd1, 32'h0000_2002, 32'hAAAA_BEEF, 0);
        idle(4);

        $display("[TB] back-pressure with three SW pushes");
        readyPct  = 0;
        mem_ready = 1'b0;
        applyStimulus(2'd2, 32'h0000_0100, 32'h1111_1111, 0);
        applyStimulus(2'd2, 32'h0000_0104, 32'h2222_2222, 0);
        applyStimulus(2'd2, 32'h0000_0108, 32'h3333_3333, 2);
        checkOutput("third_push_stalls", 32'(lastStalls), 32'd3);
        readyPct = 100;
        idle(4);

        $display("[TB] misaligned SW and back-to-back reserved sizes");
        applyStimulus(2'd2, 32'h0000_3001, 32'hCAFE_F00D, 0);
        idle(3);
        applyStimulus(2'd3, 32'h0000_4444, 32'h0BAD_0BAD, 0);
        applyStimulus(2'd3, 32'h0000_5555, 32'h0BAD_0BAD, 0);
        idle(3);

        $display("[TB] reset with two entries pending");
        readyPct  = 0;
        mem_ready = 1'b0;
        applyStimulus(2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 0);
        applyStimulus(2'd0, 32'h0000_0205, 32'h0000_00A5, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("mid");
        expQ.delete();
        errQ.delete();
        modelErrAddr = 32'd0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        readyPct  = 100;
        mem_ready = 1'b1;
        checkOutput("in_ready_after_reset", 32'(in_ready_le & in_ready_be), 32'd1);
        applyStimulus(2'd2, 32'h0000_6000, 32'h6000_6000, 0);
        idle(3);

        $display("[TB] randomized traffic");
        readyPct = 75;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 99) < 70) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: sz = 2'd0;
                    3, 4, 5: sz = 2'd1;
                    6, 7, 8: sz = 2'd2;
                    default: sz = 2'd3;
                endcase
                applyStimulus(sz, $urandom, $urandom, 0);
            end else begin
                idle(1);
            end
        end
        readyPct = 100;
        idle(6);
        checkOutput("drained", 32'(expQ.size() + errQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
